// File: rtl/div_if.sv
// Request/response bundle between the EX stage (master) and the divider (slave).
// Signal names keep the divider's own view: _i flows into div_unit, _o flows out.
//   signed_div_i  1 = signed divide (DIV), 0 = unsigned (DIVU)
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request, held high until ready_o has been seen
//   annul_i       flush of an in-flight divide
//   result_o      {remainder, quotient}
//   ready_o       result valid
interface div_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// One quotient bit per clock; the result is presented as {remainder, quotient}
// with ready_o high until the requester drops start_i.
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset
//   bus   div_if.slave: signed_div_i, opdata1_i, opdata2_i, start_i, annul_i in;
//         result_o, ready_o out
// Optional build macro DIV_EARLY_OUT_EN: when |dividend| < |divisor| the result
// (quotient 0, remainder = dividend) is produced one edge after the request.
module div_unit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);

    localparam int unsigned CntW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q;
    logic [DATA_W-1:0]   dividend_q;   // shifts left; quotient bits fill in from the LSB
    logic [DATA_W-1:0]   divisor_q;
    logic [DATA_W-1:0]   rem_q;
    logic                neg_quot_q;
    logic                neg_rem_q;
    logic [2*DATA_W-1:0] result_q;

    logic                accept;
    logic                div_zero;
    logic                early_out;
    logic                iter_done;
    logic [DATA_W-1:0]   abs_a;
    logic [DATA_W-1:0]   abs_b;
    logic [DATA_W:0]     shifted;
    logic [DATA_W:0]     trial;
    logic                qbit;
    logic [DATA_W-1:0]   rem_next;
    logic [DATA_W-1:0]   quot_fix;
    logic [DATA_W-1:0]   rem_fix;

    assign accept    = bus.start_i && !bus.annul_i;
    assign div_zero  = (bus.opdata2_i == '0);
    assign iter_done = (cnt_q == CntW'(DATA_W));

    assign abs_a = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
    assign abs_b = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;

`ifdef DIV_EARLY_OUT_EN
    assign early_out = (abs_a < abs_b);
`else
    assign early_out = 1'b0;
`endif

    // Partial remainder carries one extra bit: 2*rem can exceed DATA_W bits when
    // the divisor is large, and the trial subtraction must see that bit.
    assign shifted  = {rem_q, dividend_q[DATA_W-1]};
    assign trial    = shifted - {1'b0, divisor_q};
    assign qbit     = (shifted >= {1'b0, divisor_q});
    assign rem_next = qbit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];

    assign quot_fix = neg_quot_q ? -dividend_q : dividend_q;
    assign rem_fix  = neg_rem_q ? -rem_q : rem_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFree;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFree: begin
                if (accept) begin
                    if (div_zero) begin
                        state_d = StByZero;
                    end else if (early_out) begin
                        state_d = StEnd;
                    end else begin
                        state_d = StOn;
                    end
                end
            end
            StByZero: state_d = StEnd;
            StOn: begin
                if (bus.annul_i) begin
                    state_d = StFree;
                end else if (iter_done) begin
                    state_d = StEnd;
                end
            end
            StEnd: begin
                if (!bus.start_i) begin
                    state_d = StFree;
                end
            end
            default: state_d = StFree;
        endcase
    end

    // Outputs
    always_comb begin
        bus.ready_o  = (state_q == StEnd);
        bus.result_o = (state_q == StEnd) ? result_q : '0;
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
        end else begin
            unique case (state_q)
                StFree: begin
                    if (accept) begin
                        if (div_zero) begin
                            result_q <= '0;
                        end else if (early_out) begin
                            result_q <= {bus.opdata1_i, {DATA_W{1'b0}}};
                        end else begin
                            dividend_q <= abs_a;
                            divisor_q  <= abs_b;
                            rem_q      <= '0;
                            cnt_q      <= '0;
                            neg_quot_q <= bus.signed_div_i &&
                                          (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
                            neg_rem_q  <= bus.signed_div_i && bus.opdata1_i[DATA_W-1];
                        end
                    end
                end
                StByZero: result_q <= '0;
                StOn: begin
                    if (!bus.annul_i) begin
                        if (!iter_done) begin
                            rem_q      <= rem_next;
                            dividend_q <= {dividend_q[DATA_W-2:0], qbit};
                            cnt_q      <= cnt_q + 1'b1;
                        end else begin
                            result_q <= {rem_fix, quot_fix};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
